mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single byte-serial memory controller between three requesters:
//  instruction fetch (IF), LSB load (LD) and LSB store (ST).
//  Fixed priority is ST > LD > IF, with an aging override so that IF cannot starve.
//  A pipeline flush aborts speculative IF/LD traffic; committed stores always complete.
//  Sits between the fetch unit / LSB and the memory controller. Exactly one transaction is outstanding downstream.
// PARAMETERS
//  STARVE_LIMIT  8   cycles IF may wait while requesting before it overrides priority
//  CNT_W         4   width of the IF wait counter; must satisfy 2**CNT_W > STARVE_LIMIT
// PORTS
//  clk        in   1   clock
//  reset      in   1   reset, synchronous, active-low
//  rdy        in   1   global ready; when low, all state and outputs freeze
//  flush      in   1   mispredict flush; drop in-flight and pending IF/LD
//  if_req     in   1   IF request; held until if_done
//  if_addr    in   32  IF address; always a 4-byte read
//  if_done    out  1   1-cycle pulse; if_data valid in the same cycle
//  if_data    out  32  fetched word
//  ld_req     in   1   load request; held until ld_done
//  ld_addr    in   32  load address
//  ld_len     in   2   0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word
//  ld_done    out  1   1-cycle pulse
//  ld_data    out  32  zero-extended load data
//  st_req     in   1   store request; held until st_done
//  st_addr    in   32  store address
//  st_len     in   2   encoded as ld_len
//  st_data    in   32  store data, right-aligned
//  st_done    out  1   1-cycle pulse
//  mc_valid   out  1   downstream request; held high until mc_done
//  mc_wr      out  1   1 = write
//  mc_addr    out  32  downstream address
//  mc_len     out  2   downstream size
//  mc_wdata   out  32  downstream write data
//  mc_done    in   1   1-cycle completion pulse from the memory controller
//  mc_rdata   in   32  read data; valid with mc_done
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - state=IDLE; wait_cnt=0.
//   - All outputs 0: mc_valid, mc_wr, mc_addr, mc_len, mc_wdata, x_done, x_data.
//   - Reset mid-transaction abandons it; no done pulse is produced.
//  rdy==0: hold everything. A mc_done seen while rdy==0 is ignored.
//  FSM states: IDLE, BUSY_IF, BUSY_LD, BUSY_ST, DRAIN.
//  IDLE arbitration (all outputs registered):
//   - Request seen at edge t -> mc_valid=1 and mc_* loaded, state=BUSY_x, from t+1.
//   - Requester x is masked in any cycle where x_done==1, so a held req is not re-granted.
//   - Winner when wait_cnt >= STARVE_LIMIT and if_req: IF.
//   - Otherwise winner is ST, then LD, then IF.
//   - flush==1 in IDLE: only ST is eligible that cycle.
//  BUSY_x:
//   - mc_* held stable until mc_done.
//   - On mc_done: next cycle x_done=1, x_data=mc_rdata (IF/LD), mc_valid=0, state=IDLE.
//   - Minimum spacing between two grants: done cycle plus 1 IDLE cycle.
//  Flush during BUSY_IF/BUSY_LD (including the mc_done cycle):
//   - If mc_done is not yet seen: go to DRAIN.
//   - If mc_done arrives in the flush cycle: suppress the done pulse and return to IDLE.
//  DRAIN: mc_valid stays high until mc_done, then return to IDLE with no done pulse.
//   - A further flush while in DRAIN has no effect.
//  BUSY_ST ignores flush.
//  wait_cnt:
//   - +1 per cycle while if_req && state!=BUSY_IF && !if_done; saturates at 2**CNT_W-1.
//   - Cleared on IF grant, on flush, or when if_req==0.
//  x_done: exactly one cycle; 0 in all other cycles.
//  mc_wr: 1 only in BUSY_ST.
//  mc_wdata = st_data latched at grant; 0 for reads.
//  mc_len for IF = 2.
// CONFIGURATION
//  MEM_ARB_STATS_EN defined:
//   - Adds out ports stat_if, stat_ld, stat_st, stat_drain, 32 bits each.
//   - Each counts completed grants of that kind, wrapping at 2**32.
//   - Zeroed by reset; frozen by rdy==0.
//  Undefined: these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package/header def.v holds:
//   - state encodings ST_IDLE..ST_DRAIN (3 bits)
//   - length codes LEN_B/LEN_H/LEN_W
//   - requester ids REQ_IF/REQ_LD/REQ_ST
//  Sub-module arb_prio: combinational winner select from (if_req, ld_req, st_req, masks, starve).
//  The FSM and datapath registers stay in mem_arbiter.
// TESTING
//  - Single IF 0x100, mc_done at +3, rdata 0xDEADBEEF -> if_done once, if_data=0xDEADBEEF, mc_len=2.
//  - ld_req and st_req raised together -> ST granted first (mc_wr=1); LD granted 2 cycles after st_done.
//  - if_req held while LD/ST back-to-back for 8 cycles -> next grant is IF despite pending ld_req.
//  - Flush 1 cycle after LD grant -> mc_valid held until mc_done; ld_done never pulses; FSM back in IDLE.
//  - Flush during BUSY_ST -> st_done still pulses; pending ld_req/if_req not granted in the flush cycle.
//  - rdy low 5 cycles mid-BUSY_IF, reset mid-BUSY_ST -> outputs frozen; then all outputs 0 and state IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: FSM states, access lengths and requester ids.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BUSY_IF = 3'd1,
        ST_BUSY_LD = 3'd2,
        ST_BUSY_ST = 3'd3,
        ST_DRAIN   = 3'd4
    } state_e;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    typedef enum logic [1:0] {
        REQ_IF = 2'd0,
        REQ_LD = 2'd1,
        REQ_ST = 2'd2
    } req_e;

    // Length code 3 is illegal and is issued downstream as a word access.
    function automatic logic [1:0] norm_len(input logic [1:0] len);
        return (len == 2'd3) ? LEN_W : len;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// Combinational winner select: ST > LD > IF, with a starvation override for IF.
module arb_prio
    import mem_arbiter_pkg::*;
(
    input  logic if_req,
    input  logic ld_req,
    input  logic st_req,
    input  logic if_mask,
    input  logic ld_mask,
    input  logic st_mask,
    input  logic flush,
    input  logic starve,
    output logic gnt_valid,
    output req_e gnt_id
);

    logic if_ok;
    logic ld_ok;
    logic st_ok;

    // A flush kills speculative traffic, so only the committed store stays eligible.
    assign if_ok = if_req & ~if_mask & ~flush;
    assign ld_ok = ld_req & ~ld_mask & ~flush;
    assign st_ok = st_req & ~st_mask;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = REQ_IF;
        if (starve && if_ok) begin
            gnt_valid = 1'b1;
            gnt_id    = REQ_IF;
        end else if (st_ok) begin
            gnt_valid = 1'b1;
            gnt_id    = REQ_ST;
        end else if (ld_ok) begin
            gnt_valid = 1'b1;
            gnt_id    = REQ_LD;
        end else if (if_ok) begin
            gnt_valid = 1'b1;
            gnt_id    = REQ_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF / LD / ST onto one byte-serial memory controller, one transaction in flight.
// Optional grant statistics ports are enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rdy,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_len,
    output logic        ld_done,
    output logic [31:0] ld_data,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [1:0]  st_len,
    input  logic [31:0] st_data,
    output logic        st_done,
    output logic        mc_valid,
    output logic        mc_wr,
    output logic [31:0] mc_addr,
    output logic [1:0]  mc_len,
    output logic [31:0] mc_wdata,
    input  logic        mc_done,
    input  logic [31:0] mc_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0] stat_if,
    output logic [31:0] stat_ld,
    output logic [31:0] stat_st,
    output logic [31:0] stat_drain
`endif
);

    localparam logic [CNT_W-1:0] STARVE_CNT = CNT_W'(STARVE_LIMIT);

    state_e            state_reg, state_next;
    logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic              mc_valid_reg, mc_valid_next;
    logic              mc_wr_reg, mc_wr_next;
    logic [31:0]       mc_addr_reg, mc_addr_next;
    logic [1:0]        mc_len_reg, mc_len_next;
    logic [31:0]       mc_wdata_reg, mc_wdata_next;
    logic              if_done_reg, if_done_next;
    logic              ld_done_reg, ld_done_next;
    logic              st_done_reg, st_done_next;
    logic [31:0]       if_data_reg, if_data_next;
    logic [31:0]       ld_data_reg, ld_data_next;

    logic gnt_valid;
    req_e gnt_id;
    logic starve;
    logic any_done;
    logic grant_if;

    assign starve   = (wait_cnt_reg >= STARVE_CNT);
    assign any_done = if_done_reg | ld_done_reg | st_done_reg;

    arb_prio u_arb_prio (
        .if_req    (if_req),
        .ld_req    (ld_req),
        .st_req    (st_req),
        .if_mask   (if_done_reg),
        .ld_mask   (ld_done_reg),
        .st_mask   (st_done_reg),
        .flush     (flush),
        .starve    (starve),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        state_next    = state_reg;
        mc_valid_next = mc_valid_reg;
        mc_wr_next    = mc_wr_reg;
        mc_addr_next  = mc_addr_reg;
        mc_len_next   = mc_len_reg;
        mc_wdata_next = mc_wdata_reg;
        if_done_next  = 1'b0;
        ld_done_next  = 1'b0;
        st_done_next  = 1'b0;
        if_data_next  = if_data_reg;
        ld_data_next  = ld_data_reg;
        grant_if      = 1'b0;

        case (state_reg)
            // The done cycle itself is never a grant cycle, enforcing one idle gap.
            ST_IDLE: begin
                if (gnt_valid && !any_done) begin
                    mc_valid_next = 1'b1;
                    mc_wr_next    = (gnt_id == REQ_ST);
                    case (gnt_id)
                        REQ_IF: begin
                            state_next    = ST_BUSY_IF;
                            mc_addr_next  = if_addr;
                            mc_len_next   = LEN_W;
                            mc_wdata_next = '0;
                            grant_if      = 1'b1;
                        end
                        REQ_LD: begin
                            state_next    = ST_BUSY_LD;
                            mc_addr_next  = ld_addr;
                            mc_len_next   = norm_len(ld_len);
                            mc_wdata_next = '0;
                        end
                        REQ_ST: begin
                            state_next    = ST_BUSY_ST;
                            mc_addr_next  = st_addr;
                            mc_len_next   = norm_len(st_len);
                            mc_wdata_next = st_data;
                        end
                        default: mc_valid_next = 1'b0;
                    endcase
                end
            end
            ST_BUSY_IF, ST_BUSY_LD: begin
                if (mc_done) begin
                    state_next    = ST_IDLE;
                    mc_valid_next = 1'b0;
                    if (!flush) begin
                        if (state_reg == ST_BUSY_IF) begin
                            if_done_next = 1'b1;
                            if_data_next = mc_rdata;
                        end else begin
                            ld_done_next = 1'b1;
                            ld_data_next = mc_rdata;
                        end
                    end
                end else if (flush) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_BUSY_ST: begin
                if (mc_done) begin
                    state_next    = ST_IDLE;
                    mc_valid_next = 1'b0;
                    mc_wr_next    = 1'b0;
                    st_done_next  = 1'b1;
                end
            end
            // Keep the request up so the controller finishes cleanly; the result is discarded.
            ST_DRAIN: begin
                if (mc_done) begin
                    state_next    = ST_IDLE;
                    mc_valid_next = 1'b0;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                mc_valid_next = 1'b0;
                mc_wr_next    = 1'b0;
            end
        endcase

        wait_cnt_next = wait_cnt_reg;
        if (!if_req || flush || grant_if) begin
            wait_cnt_next = '0;
        end else if (state_reg != ST_BUSY_IF && !if_done_reg && wait_cnt_reg != {CNT_W{1'b1}}) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            mc_valid_reg <= 1'b0;
            mc_wr_reg    <= 1'b0;
            mc_addr_reg  <= '0;
            mc_len_reg   <= '0;
            mc_wdata_reg <= '0;
            if_done_reg  <= 1'b0;
            ld_done_reg  <= 1'b0;
            st_done_reg  <= 1'b0;
            if_data_reg  <= '0;
            ld_data_reg  <= '0;
        end else if (rdy) begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            mc_valid_reg <= mc_valid_next;
            mc_wr_reg    <= mc_wr_next;
            mc_addr_reg  <= mc_addr_next;
            mc_len_reg   <= mc_len_next;
            mc_wdata_reg <= mc_wdata_next;
            if_done_reg  <= if_done_next;
            ld_done_reg  <= ld_done_next;
            st_done_reg  <= st_done_next;
            if_data_reg  <= if_data_next;
            ld_data_reg  <= ld_data_next;
        end
    end

    assign mc_valid = mc_valid_reg;
    assign mc_wr    = mc_wr_reg;
    assign mc_addr  = mc_addr_reg;
    assign mc_len   = mc_len_reg;
    assign mc_wdata = mc_wdata_reg;
    assign if_done  = if_done_reg;
    assign ld_done  = ld_done_reg;
    assign st_done  = st_done_reg;
    assign if_data  = if_data_reg;
    assign ld_data  = ld_data_reg;

`ifdef MEM_ARB_STATS_EN
    logic       drop_done;
    logic [3:0] stat_inc;

    // A flushed IF/LD that finishes, either via DRAIN or in the flush cycle, counts as a drain.
    assign drop_done = mc_done && ((state_reg == ST_DRAIN) ||
                       (flush && (state_reg == ST_BUSY_IF || state_reg == ST_BUSY_LD)));
    assign stat_inc  = {drop_done, st_done_next, ld_done_next, if_done_next};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_stat
            logic [31:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (!reset) begin
                    cnt_reg <= '0;
                end else if (rdy && stat_inc[gi]) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign stat_if    = g_stat[0].cnt_reg;
    assign stat_ld    = g_stat[1].cnt_reg;
    assign stat_st    = g_stat[2].cnt_reg;
    assign stat_drain = g_stat[3].cnt_reg;
`endif

endmodule
